mem_lat_arb: RTL
================

MEM_LAT_ARB -- requirements
Module: mem_lat_arb

Interface
- REQ-001 SHALL have parameter NumPorts, default 2: number of requesting ports, 1..8.
- REQ-002 SHALL have parameter AddrWidth, default 64: request address width.
- REQ-003 SHALL have parameter DataWidth, default 64: data width, multiple of 8.
- REQ-004 SHALL have parameter Latency, default 2: cycles from grant to response, 1..8.
- REQ-005 SHALL have parameter StallRandom, default 1'b0: enables pseudo-random grant stalls.
- REQ-006 SHALL have parameter LfsrSeed, default 16'hACE1: stall LFSR reset value, nonzero.
- REQ-007 SHALL have port clk_i, input, 1: sole clock; all state on rising edge.
- REQ-008 SHALL have port rst_i, input, 1: reset, asynchronous, active-high.
- REQ-009 SHALL have port req_i, input, [NumPorts]: per-port request.
- REQ-010 SHALL have port we_i, input, [NumPorts]: per-port write enable.
- REQ-011 SHALL have port addr_i, input, [NumPorts][AddrWidth]: per-port address.
- REQ-012 SHALL have port be_i, input, [NumPorts][DataWidth/8]: per-port byte enables.
- REQ-013 SHALL have port wdata_i, input, [NumPorts][DataWidth]: per-port write data.
- REQ-014 SHALL have port gnt_o, output, [NumPorts]: per-port grant, combinational.
- REQ-015 SHALL have port rvalid_o, output, [NumPorts]: per-port response valid.
- REQ-016 SHALL have port rdata_o, output, [NumPorts][DataWidth]: per-port read data.
- REQ-017 SHALL have ports mem_req_o/mem_we_o (1), mem_addr_o (AddrWidth), mem_be_o (DataWidth/8), mem_wdata_o (DataWidth), all outputs: backend request.
- REQ-018 SHALL have port mem_rdata_i, input, DataWidth: backend read data, valid exactly one cycle after mem_req_o.

Function
- REQ-019 SHALL grant at most one port per cycle; a request completes in the cycle where req_i[p] and gnt_o[p] are both high.
- REQ-020 SHALL arbitrate round-robin: search starts at pointer rr_q, ascending, wrapping at NumPorts-1 to 0.
- REQ-021 SHALL set rr_q to (granted index + 1) mod NumPorts after each grant; rr_q SHALL hold when no grant occurs.
- REQ-022 SHALL drive mem_req_o = |gnt_o and forward the granted port's we/addr/be/wdata on mem_* in the same cycle; idle mem_* fields SHALL be 0.
- REQ-023 When StallRandom=1, SHALL suppress all grants in any cycle where lfsr_q[0]=1; 16-bit Fibonacci LFSR, taps 16,14,13,11, SHALL advance every cycle regardless of requests.
- REQ-024 When StallRandom=0, SHALL never suppress grants; the LFSR SHALL remain constant.
- REQ-025 SHALL assert rvalid_o[p] for exactly one cycle, exactly Latency cycles after the grant cycle of port p, for both reads and writes.
- REQ-026 SHALL capture mem_rdata_i one cycle after grant and delay it Latency-1 further cycles; Latency=1 SHALL present mem_rdata_i directly on rdata_o.
- REQ-027 SHALL drive rdata_o[p] = captured data on a read response; 0 on a write response and whenever rvalid_o[p]=0.
- REQ-028 SHALL sustain one grant per cycle back-to-back with no bubble; the response pipeline SHALL carry Latency independent entries (valid, port index, we, data).
- REQ-029 Responses SHALL return in grant order; a port granted in consecutive cycles SHALL see rvalid_o in consecutive cycles.
- REQ-030 SHALL not gate grants on response state; response ports have no back-pressure.
- REQ-031 With NumPorts=1, arbitration SHALL reduce to gnt_o[0] = req_i[0] & ~stall.

Reset
- REQ-032 On rst_i high, SHALL asynchronously clear rr_q to 0, lfsr_q to LfsrSeed, and all pipeline valids to 0.
- REQ-033 During reset, gnt_o, rvalid_o, rdata_o and mem_req_o SHALL be 0.
- REQ-034 Reset mid-operation SHALL drop all in-flight responses; no rvalid_o SHALL assert for grants issued before reset.
- REQ-035 First grant after reset release SHALL occur no earlier than the first rising edge with rst_i low.

Verification
- REQ-036 NumPorts=2, Latency=2, StallRandom=0: write 0xDEADBEEF_CAFEF00D to addr 0x100 from port 0 (be=0xFF), then read 0x100 from port 1 -> gnt_o[1] next cycle; rvalid_o[1] 2 cycles after its grant; rdata_o[1]=0xDEADBEEF_CAFEF00D.
- REQ-037 Both ports requesting continuously for 6 cycles from reset -> grants alternate 0,1,0,1,0,1; rvalid_o pattern mirrors it delayed by Latency.
- REQ-038 Latency=1 vs Latency=4, single read from port 0 -> rvalid_o[0] 1 vs 4 cycles after grant; exactly one pulse each.
- REQ-039 Assert rst_i one cycle after 3 back-to-back grants with Latency=4 -> no rvalid_o asserts after reset; rr_q=0; next grant goes to port 0 when both request.
- REQ-040 StallRandom=1, LfsrSeed=16'hACE1, port 0 requesting continuously for 64 cycles -> grant cycles exactly match ~lfsr_q[0] from the reference LFSR sequence; every grant yields a response Latency cycles later.

Source files
------------

// File: rtl/mem_lat_arb.sv
// Round-robin arbiter in front of a fixed-latency memory backend.
// Grants one port per cycle and returns each response to its port
// exactly Latency cycles after the grant, in grant order.
module mem_lat_arb #(
  parameter int          NumPorts    = 2,
  parameter int          AddrWidth   = 64,
  parameter int          DataWidth   = 64,
  parameter int          Latency     = 2,
  parameter logic        StallRandom = 1'b0,
  parameter logic [15:0] LfsrSeed    = 16'hACE1
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [NumPorts-1:0]                   req_i,
  input  logic [NumPorts-1:0]                   we_i,
  input  logic [NumPorts-1:0][AddrWidth-1:0]    addr_i,
  input  logic [NumPorts-1:0][DataWidth/8-1:0]  be_i,
  input  logic [NumPorts-1:0][DataWidth-1:0]    wdata_i,
  output logic [NumPorts-1:0]                   gnt_o,
  output logic [NumPorts-1:0]                   rvalid_o,
  output logic [NumPorts-1:0][DataWidth-1:0]    rdata_o,
  output logic                                  mem_req_o,
  output logic                                  mem_we_o,
  output logic [AddrWidth-1:0]                  mem_addr_o,
  output logic [DataWidth/8-1:0]                mem_be_o,
  output logic [DataWidth-1:0]                  mem_wdata_o,
  input  logic [DataWidth-1:0]                  mem_rdata_i
);

  // A single-port build still needs a 1-bit index.
  localparam int IdxW = (NumPorts > 1) ? $clog2(NumPorts) : 1;

  logic [IdxW-1:0]      rr_q, rr_d;
  logic [15:0]          lfsr_q, lfsr_d;
  logic                 stall;
  logic [IdxW-1:0]      gnt_idx;
  logic                 gnt_any;

  // Response pipeline: stage s is visible s+1 cycles after the grant.
  logic                 v_q    [Latency];
  logic [IdxW-1:0]      port_q [Latency];
  logic                 we_q   [Latency];
  logic [DataWidth-1:0] out_data;

  // Fibonacci LFSR (taps 16,14,13,11), right-shifting; frozen when stalls are disabled.
  always_comb begin
    lfsr_d = lfsr_q;
    if (StallRandom) begin
      lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    end
  end

  assign stall = StallRandom & lfsr_q[0];

  // Round-robin search starting at rr_q; grants are forced low during reset.
  always_comb begin
    int j;
    gnt_o   = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    j       = 0;
    if (!rst_i && !stall) begin
      for (int k = 0; k < NumPorts; k++) begin
        j = int'(rr_q) + k;
        if (j >= NumPorts) j = j - NumPorts;
        if (!gnt_any && req_i[j]) begin
          gnt_any = 1'b1;
          gnt_idx = j[IdxW-1:0];
        end
      end
      if (gnt_any) gnt_o[gnt_idx] = 1'b1;
    end
  end

  // Pointer moves one past the winner; holds when nothing is granted.
  always_comb begin
    rr_d = rr_q;
    if (gnt_any) begin
      rr_d = (gnt_idx == IdxW'(NumPorts - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  // Forward the winning port's request fields; all zero when idle.
  always_comb begin
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    for (int p = 0; p < NumPorts; p++) begin
      if (gnt_o[p]) begin
        mem_we_o    = we_i[p];
        mem_addr_o  = addr_i[p];
        mem_be_o    = be_i[p];
        mem_wdata_o = wdata_i[p];
      end
    end
  end

  assign mem_req_o = gnt_any;

  // Arbitration pointer and LFSR state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q   <= '0;
      lfsr_q <= LfsrSeed;
    end else begin
      rr_q   <= rr_d;
      lfsr_q <= lfsr_d;
    end
  end

  // Control pipeline: one independent entry per stage, no back-pressure.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int s = 0; s < Latency; s++) begin
        v_q[s]    <= 1'b0;
        port_q[s] <= '0;
        we_q[s]   <= 1'b0;
      end
    end else begin
      v_q[0]    <= gnt_any;
      port_q[0] <= gnt_idx;
      we_q[0]   <= mem_we_o;
      for (int s = 1; s < Latency; s++) begin
        v_q[s]    <= v_q[s-1];
        port_q[s] <= port_q[s-1];
        we_q[s]   <= we_q[s-1];
      end
    end
  end

  // Read data arrives one cycle after the grant; delay it to line up with the last stage.
  if (Latency > 1) begin : g_dly
    logic [DataWidth-1:0] data_q [Latency-1];

    // data_q[s] travels alongside control stage s+1.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        for (int s = 0; s < Latency - 1; s++) data_q[s] <= '0;
      end else begin
        data_q[0] <= mem_rdata_i;
        for (int s = 1; s < Latency - 1; s++) data_q[s] <= data_q[s-1];
      end
    end

    assign out_data = data_q[Latency-2];
  end else begin : g_direct
    assign out_data = mem_rdata_i;
  end

  // Steer the final stage to its port; write responses carry no data.
  for (genvar gi = 0; gi < NumPorts; gi++) begin : g_resp
    assign rvalid_o[gi] = v_q[Latency-1] && (port_q[Latency-1] == IdxW'(gi));
    assign rdata_o[gi]  = (rvalid_o[gi] && !we_q[Latency-1]) ? out_data : '0;
  end

endmodule
